store_buffer: RTL and testbench



---
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Four-entry posted-write buffer in front of a single-port data memory.
// Stores drain in FIFO order when the port is idle; loads win the port and forward from the youngest matching entry.
module store_buffer_match (
  input  logic [31:0] entry_addr,
  input  logic [31:0] addr,
  output logic        hit
);
  // Bit 10 is dropped by the memory's word mapping, so 0x800 and 0xC00 alias.
  localparam logic [31:0] KEY_MASK = ~32'h0000_0403;

  assign hit = (entry_addr & KEY_MASK) == (addr & KEY_MASK);
endmodule

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic        ld_valid,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        mem_writeEn,
  output logic        mem_readEn,
  output logic [31:0] mem_address,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [31:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_nxt;
  logic [DEPTH-1:0] ent_hit;
  logic          full, push, pop;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;

  assign full  = count == CNT_FULL;
  assign push  = st_valid && !full;
  assign pop   = !ld_valid && (count != '0);
  assign stall = st_valid && full && !rst;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    store_buffer_match u_match (
      .entry_addr(ent_addr[g]),
      .addr      (addr),
      .hit       (ent_hit[g])
    );
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + i[PW-1:0];
      if (i[PW:0] < count && ent_hit[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data[idx];
      end
    end
  end

  always_comb begin
    if (addr < 32'd1024)  ld_data = '0;
    else if (fwd_hit)     ld_data = fwd_data;
    else                  ld_data = mem_dataOut;
  end

  always_comb begin
    mem_writeEn = 1'b0;
    mem_readEn  = 1'b0;
    mem_address = '0;
    mem_dataIn  = '0;
    if (ld_valid) begin
      mem_readEn  = 1'b1;
      mem_address = addr;
    end else if (count != '0) begin
      mem_writeEn = 1'b1;
      mem_address = ent_addr[head];
      mem_dataIn  = ent_data[head];
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CNT_ONE;
    else if (!push && pop) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ent_addr[tail] <= addr;
        ent_data[tail] <= st_data;
        tail           <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count_nxt;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus queues per-cycle expectations, a negedge monitor compares.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst, st_valid, ld_valid;
  logic [31:0] addr, st_data, ld_data, mem_address, mem_dataIn, mem_dataOut;
  logic        stall, mem_writeEn, mem_readEn;

  typedef struct {
    logic        chk;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rd;
    logic        chk_ld;
    logic [31:0] ld;
    logic        stall;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Memory read word is a fixed function of the address so expectations are hand-computable.
  assign mem_dataOut = mem_address + 32'h1000_0000;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .ld_valid(ld_valid),
    .addr(addr), .st_data(st_data), .ld_data(ld_data), .stall(stall),
    .mem_writeEn(mem_writeEn), .mem_readEn(mem_readEn),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp("writeEn", {31'd0, mem_writeEn}, {31'd0, e.wr});
        if (e.wr) begin
          cmp("wr_addr", mem_address, e.wa);
          cmp("wr_data", mem_dataIn, e.wd);
        end
        cmp("readEn", {31'd0, mem_readEn}, {31'd0, e.rd});
        cmp("stall", {31'd0, stall}, {31'd0, e.stall});
        if (e.chk_ld) cmp("ld_data", ld_data, e.ld);
      end
    end
  end

  // One cycle: drive inputs after the edge, queue what the outputs must be during that cycle.
  task automatic cyc(input logic r, input logic st, input logic ld,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic ewr, input logic [31:0] ewa, input logic [31:0] ewd,
                     input logic echk_ld, input logic [31:0] eld, input logic estall,
                     input logic chk = 1'b1);
    exp_t e;
    @(posedge clk); #1;
    rst = r; st_valid = st; ld_valid = ld; addr = a; st_data = d;
    e.chk = chk; e.wr = ewr; e.wa = ewa; e.wd = ewd; e.rd = ld;
    e.chk_ld = echk_ld; e.ld = eld; e.stall = estall;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic ewr, input logic [31:0] ewa, input logic [31:0] ewd);
    cyc(0, 0, 0, 32'h0, 32'h0, ewr, ewa, ewd, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; ld_valid = 1'b0; addr = '0; st_data = '0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);

    // Single store drains one cycle after acceptance.
    cyc(0, 1, 0, 32'h400, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle(1, 32'h400, 32'hDEADBEEF);
    idle(0, 0, 0);

    // Fill under continuous loads, stall, then drain in order.
    cyc(0, 1, 1, 32'h500, 32'h11, 0, 0, 0, 1, 32'h1000_0500, 0);
    cyc(0, 1, 1, 32'h504, 32'h22, 0, 0, 0, 1, 32'h1000_0504, 0);
    cyc(0, 1, 1, 32'h508, 32'h33, 0, 0, 0, 1, 32'h1000_0508, 0);
    cyc(0, 1, 1, 32'h50C, 32'h44, 0, 0, 0, 1, 32'h1000_050C, 0);
    cyc(0, 1, 1, 32'h510, 32'h55, 0, 0, 0, 1, 32'h1000_0510, 1);
    cyc(0, 1, 0, 32'h510, 32'h55, 1, 32'h500, 32'h11, 0, 0, 1);
    cyc(0, 1, 0, 32'h510, 32'h55, 1, 32'h504, 32'h22, 0, 0, 0);
    idle(1, 32'h508, 32'h33);
    idle(1, 32'h50C, 32'h44);
    idle(1, 32'h510, 32'h55);
    idle(0, 0, 0);

    // Youngest of two same-address stores is forwarded.
    cyc(0, 1, 1, 32'h600, 32'h1, 0, 0, 0, 1, 32'h1000_0600, 0);
    cyc(0, 1, 1, 32'h600, 32'h2, 0, 0, 0, 1, 32'h1, 0);
    cyc(0, 0, 1, 32'h600, 32'h0, 0, 0, 0, 1, 32'h2, 0);
    idle(1, 32'h600, 32'h1);
    idle(1, 32'h600, 32'h2);
    idle(0, 0, 0);

    // Bit-10 alias forwards; reserved region reads zero; non-matching key reads memory.
    cyc(0, 1, 1, 32'h800, 32'hAA, 0, 0, 0, 1, 32'h1000_0800, 0);
    cyc(0, 0, 1, 32'hC00, 32'h0, 0, 0, 0, 1, 32'hAA, 0);
    cyc(0, 0, 1, 32'h3FC, 32'h0, 0, 0, 0, 1, 32'h0, 0);
    cyc(0, 0, 1, 32'h804, 32'h0, 0, 0, 0, 1, 32'h1000_0804, 0);
    idle(1, 32'h800, 32'hAA);
    idle(0, 0, 0);

    // Simultaneous load and store to an empty buffer: load does not see the store.
    cyc(0, 1, 1, 32'h900, 32'h7, 0, 0, 0, 1, 32'h1000_0900, 0);
    idle(1, 32'h900, 32'h7);
    idle(0, 0, 0);

    // Reset with three pending entries discards them.
    cyc(0, 1, 1, 32'hA00, 32'h1, 0, 0, 0, 1, 32'h1000_0A00, 0);
    cyc(0, 1, 1, 32'hA04, 32'h2, 0, 0, 0, 1, 32'h1000_0A04, 0);
    cyc(0, 1, 1, 32'hA08, 32'h3, 0, 0, 0, 1, 32'h1000_0A08, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    cyc(0, 0, 1, 32'hA04, 32'h0, 0, 0, 0, 1, 32'h1000_0A04, 0);
    idle(0, 0, 0);
    idle(0, 0, 0);

    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
